// File: rtl/move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : move_scheduler
//  Purpose  : Decodes PS/2 arrow-key make codes into direction requests,
//             filters and buffers them in a 2-entry queue, and commits one
//             direction per game step issued over a req/ack handshake that
//             is paced by a programmable tick divider.
//  Revision : 1.0 - initial release
// ============================================================================
module move_scheduler #(
   parameter int         TICK_DIV = 2500000,
   parameter logic [1:0] INIT_DIR = 2'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       newKey,
   input  logic [7:0] keyCode,
   input  logic       enable,
   input  logic       restart,
   input  logic       step_ack,
   output logic       step_req,
   output logic [1:0] dir,
   output logic       dropped,
   output logic [1:0] q_count
);

   // Counter width; TICK_DIV is at least 2 so this is never zero
   localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] C_LAST   = CW'(TICK_DIV - 1);

   // Scan codes of interest
   localparam logic [7:0]    C_KEY_BRK   = 8'hF0;
   localparam logic [7:0]    C_KEY_EXT   = 8'hE0;
   localparam logic [7:0]    C_KEY_RIGHT = 8'h74;
   localparam logic [7:0]    C_KEY_UP    = 8'h75;
   localparam logic [7:0]    C_KEY_LEFT  = 8'h6B;
   localparam logic [7:0]    C_KEY_DOWN  = 8'h72;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_count;
   logic            r_step_req;
   logic [1:0]      r_dir;
   logic            r_brk;
   logic [1:0]      r_q0;        // queue head
   logic [1:0]      r_q1;        // second entry (tail when full)
   logic [1:0]      r_qcnt;
   logic            r_dropped;

   logic            w_key_valid;
   logic [1:0]      w_key_dir;
   logic            w_tick;
   logic            w_pop;
   logic [1:0]      w_tail;
   logic [1:0]      w_cnt_pp;
   logic            w_reject;
   logic            w_key_live;
   logic            w_push;
   logic            w_drop;
   logic [1:0]      w_q0_n;
   logic [1:0]      w_q1_n;
   logic [1:0]      w_cnt_n;

   // Arrow make-code decode; anything following a break prefix is ignored
   always_comb begin
      w_key_valid = 1'b0;
      w_key_dir   = 2'd0;
      if (newKey && !r_brk) begin
         w_key_valid = 1'b1;
         case (keyCode)
            C_KEY_RIGHT: w_key_dir = 2'd0;
            C_KEY_UP:    w_key_dir = 2'd1;
            C_KEY_LEFT:  w_key_dir = 2'd2;
            C_KEY_DOWN:  w_key_dir = 2'd3;
            default:     w_key_valid = 1'b0;
         endcase
      end
   end

   // Tick edge: last IDLE count while running; restart suppresses it
   assign w_tick = (r_state == IDLE) && enable && !restart && (r_count == C_LAST);
   assign w_pop  = w_tick && (r_qcnt != 2'd0);

   // Filter reference. When a pop empties a 1-entry queue the popped head
   // becomes dir, which equals the old tail, so the pre-pop tail is correct
   // in every case.
   assign w_tail     = (r_qcnt == 2'd2) ? r_q1 :
                       (r_qcnt == 2'd1) ? r_q0 : r_dir;
   assign w_cnt_pp   = r_qcnt - {1'b0, w_pop};
   assign w_reject   = (w_key_dir == w_tail) ||
                       (w_key_dir == (w_tail ^ 2'd2)) ||
                       (w_cnt_pp == 2'd2);
   assign w_key_live = enable && !restart && w_key_valid;
   assign w_push     = w_key_live && !w_reject;
   assign w_drop     = w_key_live && w_reject;

   // Next queue contents: apply the pop first, then append the push
   always_comb begin
      w_q0_n  = w_pop ? r_q1 : r_q0;
      w_q1_n  = r_q1;
      w_cnt_n = w_cnt_pp;
      if (w_push) begin
         if (w_cnt_pp == 2'd0) begin
            w_q0_n = w_key_dir;
         end else begin
            w_q1_n = w_key_dir;
         end
         w_cnt_n = w_cnt_pp + 2'd1;
      end
   end

   // Break-prefix flag tracking the PS/2 byte stream
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_brk <= 1'b0;
      end else if (restart) begin
         r_brk <= 1'b0;
      end else if (newKey) begin
         if (keyCode == C_KEY_BRK) begin
            r_brk <= 1'b1;
         end else if (keyCode != C_KEY_EXT) begin
            r_brk <= 1'b0;
         end
      end
   end

   // Direction queue storage; flushed by restart or while disabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q0   <= 2'd0;
         r_q1   <= 2'd0;
         r_qcnt <= 2'd0;
      end else if (restart || !enable) begin
         r_qcnt <= 2'd0;
      end else begin
         r_q0   <= w_q0_n;
         r_q1   <= w_q1_n;
         r_qcnt <= w_cnt_n;
      end
   end

   // One-cycle pulse for a decoded arrow request that was discarded
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dropped <= 1'b0;
      end else begin
         r_dropped <= w_drop;
      end
   end

   // Step pacing FSM: tick divider, req/ack handshake and direction commit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_step_req <= 1'b0;
         r_dir      <= INIT_DIR;
      end else begin
         case (r_state)
            IDLE: begin
               if (restart || !enable) begin
                  r_count <= '0;
               end else if (r_count == C_LAST) begin
                  r_state    <= REQ;
                  r_step_req <= 1'b1;
                  r_count    <= '0;
                  if (r_qcnt != 2'd0) begin
                     r_dir <= r_q0;
                  end
               end else begin
                  r_count <= r_count + CW'(1);
               end
            end
            REQ: begin
               // Counter stays frozen; the handshake completes even if
               // enable dropped or a restart arrived meanwhile
               if (step_ack) begin
                  r_state    <= IDLE;
                  r_step_req <= 1'b0;
                  r_count    <= '0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_step_req <= 1'b0;
               r_count    <= '0;
            end
         endcase
         // Restart overrides any commit on the same edge
         if (restart) begin
            r_dir <= INIT_DIR;
         end
      end
   end

   assign step_req = r_step_req;
   assign dir      = r_dir;
   assign dropped  = r_dropped;
   assign q_count  = r_qcnt;

endmodule
`default_nettype wire

// File: tb/tb_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_move_scheduler
//  Purpose  : Self-checking bench for move_scheduler. A behavioural model
//             (SV queue of directions, integer tick counter) predicts every
//             output each cycle; directed scenarios are followed by a
//             randomized run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_move_scheduler;

   localparam int         TD   = 4;
   localparam logic [1:0] INIT = 2'd0;

   logic       clk = 1'b0;
   logic       reset;
   logic       newKey;
   logic [7:0] keyCode;
   logic       enable;
   logic       restart;
   logic       step_ack;
   logic       step_req;
   logic [1:0] dir;
   logic       dropped;
   logic [1:0] q_count;

   move_scheduler #(
      .TICK_DIV (TD),
      .INIT_DIR (INIT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .newKey   (newKey),
      .keyCode  (keyCode),
      .enable   (enable),
      .restart  (restart),
      .step_ack (step_ack),
      .step_req (step_req),
      .dir      (dir),
      .dropped  (dropped),
      .q_count  (q_count)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model state
   logic [1:0] m_q[$];
   logic [1:0] m_dir  = INIT;
   bit         m_req  = 1'b0;
   bit         m_drop = 1'b0;
   bit         m_brk  = 1'b0;
   int         m_cnt  = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the currently driven inputs
   task automatic model_edge();
      bit         arrow;
      logic [1:0] kd;
      logic [1:0] rf;
      arrow  = 1'b0;
      kd     = 2'd0;
      m_drop = 1'b0;
      if (newKey) begin
         if (keyCode == 8'hF0) m_brk = 1'b1;
         else if (keyCode == 8'hE0) m_brk = m_brk;
         else if (m_brk) m_brk = 1'b0;
         else begin
            arrow = 1'b1;
            case (keyCode)
               8'h74:   kd = 2'd0;
               8'h75:   kd = 2'd1;
               8'h6B:   kd = 2'd2;
               8'h72:   kd = 2'd3;
               default: arrow = 1'b0;
            endcase
         end
      end
      if (restart) begin
         m_brk = 1'b0;
         m_q.delete();
         m_dir = INIT;
         m_cnt = 0;
         if (m_req && step_ack) m_req = 1'b0;
         return;
      end
      if (m_req) begin
         if (step_ack) begin
            m_req = 1'b0;
            m_cnt = 0;
         end
      end else if (!enable) begin
         m_cnt = 0;
      end else if (m_cnt == TD - 1) begin
         m_req = 1'b1;
         m_cnt = 0;
         if (m_q.size() > 0) m_dir = m_q.pop_front();
      end else begin
         m_cnt++;
      end
      if (!enable) begin
         m_q.delete();
      end else if (arrow) begin
         rf = (m_q.size() > 0) ? m_q[$] : m_dir;
         if (kd == rf || kd == (rf ^ 2'd2) || m_q.size() == 2) m_drop = 1'b1;
         else m_q.push_back(kd);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("step_req", 8'(step_req), 8'(m_req));
      check("dir",      8'(dir),      8'(m_dir));
      check("dropped",  8'(dropped),  8'(m_drop));
      check("q_count",  8'(q_count),  8'(m_q.size()));
   endtask

   task automatic key(input logic [7:0] code);
      newKey  = 1'b1;
      keyCode = code;
      cycle();
      newKey  = 1'b0;
      keyCode = 8'h00;
   endtask

   task automatic wait_req();
      int i;
      i = 0;
      while (!m_req && i < 50) begin
         cycle();
         i++;
      end
      check("wait_req", 8'(step_req), 8'd1);
   endtask

   task automatic clean();
      restart  = 1'b1;
      step_ack = 1'b1;
      cycle();
      restart  = 1'b0;
      step_ack = 1'b0;
   endtask

   initial begin
      reset    = 1'b0;
      newKey   = 1'b0;
      keyCode  = 8'h00;
      enable   = 1'b0;
      restart  = 1'b0;
      step_ack = 1'b0;
      #2;
      check("rst_step_req", 8'(step_req), 8'd0);
      check("rst_dir",      8'(dir),      8'(INIT));
      check("rst_dropped",  8'(dropped),  8'd0);
      check("rst_q_count",  8'(q_count),  8'd0);
      @(negedge clk);
      reset = 1'b1;

      // Pacing with immediate ack
      enable   = 1'b1;
      step_ack = 1'b1;
      repeat (22) cycle();

      // Break filtering while REQ is held (no pops)
      clean();
      wait_req();
      key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h75);
      check("brk_q_count", 8'(q_count), 8'd1);

      // Reversal and duplicate
      clean();
      wait_req();
      key(8'h6B);
      check("rev_q_count", 8'(q_count), 8'd0);
      key(8'h74);

      // Queue order and full-queue drop
      key(8'h75); key(8'h6B); key(8'h72);
      check("full_q_count", 8'(q_count), 8'd2);
      step_ack = 1'b1;
      repeat (12) cycle();

      // Push/pop collision on the tick edge
      clean();
      wait_req();
      key(8'h75); key(8'h6B);
      step_ack = 1'b1;
      cycle();
      step_ack = 1'b0;
      for (int i = 0; i < 50 && !(m_cnt == TD - 1 && !m_req); i++) cycle();
      key(8'h72);
      check("coll_q_count", 8'(q_count), 8'd2);
      check("coll_dir",     8'(dir),     8'd1);
      step_ack = 1'b1;
      repeat (12) cycle();

      // Held handshake with restart in the middle
      clean();
      wait_req();
      key(8'h75);
      repeat (5) cycle();
      restart = 1'b1;
      cycle();
      restart = 1'b0;
      repeat (4) cycle();
      check("held_step_req", 8'(step_req), 8'd1);
      step_ack = 1'b1;
      cycle();
      step_ack = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 2500; n++) begin
         newKey = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 7))
            0:       keyCode = 8'h74;
            1:       keyCode = 8'h75;
            2:       keyCode = 8'h6B;
            3:       keyCode = 8'h72;
            4:       keyCode = 8'hF0;
            5:       keyCode = 8'hE0;
            default: keyCode = 8'($urandom_range(0, 255));
         endcase
         enable   = ($urandom_range(0, 19) != 0);
         restart  = ($urandom_range(0, 49) == 0);
         step_ack = ($urandom_range(0, 2) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
